// File: rtl/div_pkg.sv
// Shared types and helpers for the iterative restoring divider div_iter.
package div_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  // The counter must be able to hold A_W itself: the cycle after the last
  // iteration registers the final result.
  function automatic int cnt_width(input int a_w);
    return $clog2(a_w + 1);
  endfunction

endpackage

// File: rtl/div_step.sv
// One radix-2 restoring step: shift in a dividend bit, trial-subtract the
// divisor, keep or restore, and emit one quotient bit.
module div_step #(
  parameter int B_W = 5
) (
  input  logic [B_W:0]   i_rem,
  input  logic           i_bit,
  input  logic [B_W-1:0] i_b,
  output logic [B_W:0]   o_rem,
  output logic           o_q_bit
);

  logic [B_W:0] shifted;
  logic [B_W:0] trial;

  // The incoming remainder is always below the divisor, so its top bit is
  // zero and the shifted value fits in B_W+1 bits without loss.
  always_comb begin
    shifted = (B_W+1)'({i_rem, i_bit});
    trial   = shifted - {1'b0, i_b};
    o_q_bit = (shifted >= {1'b0, i_b});
    o_rem   = o_q_bit ? trial : shifted;
  end

endmodule

// File: rtl/div_iter.sv
// Iterative radix-2 restoring divider, one quotient bit per cycle.
// Define DIV_ITER_SIGNED_EN for two's-complement operands and results.
module div_iter
  import div_pkg::*;
#(
  parameter int A_W = 8,
  parameter int B_W = 5
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           i_in_valid,
  output logic           o_in_ready,
  input  logic [A_W-1:0] i_a,
  input  logic [B_W-1:0] i_b,
  output logic           o_out_valid,
  input  logic           i_out_ready,
  output logic [A_W-1:0] o_q,
  output logic [B_W-1:0] o_r,
  output logic           o_dz
);

  localparam int               CNT_W    = cnt_width(A_W);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(A_W);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [A_W-1:0]   acc_q, acc_d;     // dividend shifts out MSB-first, quotient shifts in
  logic [B_W-1:0]   div_q, div_d;
  logic [B_W:0]     rem_q, rem_d;
  logic [A_W-1:0]   q_out_q, q_out_d;
  logic [B_W-1:0]   r_out_q, r_out_d;
  logic             dz_q, dz_d;

  logic [B_W:0]     step_rem;
  logic             step_bit;
  logic [A_W-1:0]   a_mag, q_fin;
  logic [B_W-1:0]   b_mag, r_fin, r_dz;

  div_step #(.B_W(B_W)) u_step (
    .i_rem   (rem_q),
    .i_bit   (acc_q[A_W-1]),
    .i_b     (div_q),
    .o_rem   (step_rem),
    .o_q_bit (step_bit)
  );

`ifdef DIV_ITER_SIGNED_EN
  logic q_neg_q, q_neg_d;
  logic r_neg_q, r_neg_d;

  // The core divides magnitudes; signs are reapplied when the result is
  // registered. The most-negative quotient wraps naturally on negation.
  always_comb begin
    a_mag = i_a[A_W-1] ? -i_a : i_a;
    b_mag = i_b[B_W-1] ? -i_b : i_b;
    q_fin = q_neg_q ? -acc_q : acc_q;
    r_fin = r_neg_q ? -rem_q[B_W-1:0] : rem_q[B_W-1:0];
    r_dz  = r_neg_q ? -acc_q[B_W-1:0] : acc_q[B_W-1:0];
  end
`else
  always_comb begin
    a_mag = i_a;
    b_mag = i_b;
    q_fin = acc_q;
    r_fin = rem_q[B_W-1:0];
    r_dz  = acc_q[B_W-1:0];
  end
`endif

  // NOTE: every signal written here gets a default first, so no path can
  // leave one unassigned and infer a latch.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    acc_d      = acc_q;
    div_d      = div_q;
    rem_d      = rem_q;
    q_out_d    = q_out_q;
    r_out_d    = r_out_q;
    dz_d       = dz_q;
    o_in_ready = 1'b0;
`ifdef DIV_ITER_SIGNED_EN
    q_neg_d    = q_neg_q;
    r_neg_d    = r_neg_q;
`endif

    unique case (state_q)
      ST_IDLE: begin
        o_in_ready = 1'b1;
        if (i_in_valid) begin
          acc_d   = a_mag;
          div_d   = b_mag;
          rem_d   = '0;
          cnt_d   = '0;
          state_d = ST_BUSY;
`ifdef DIV_ITER_SIGNED_EN
          q_neg_d = i_a[A_W-1] ^ i_b[B_W-1];
          r_neg_d = i_a[A_W-1];
`endif
        end
      end

      ST_BUSY: begin
        if (div_q == '0) begin
          // Zero divisor: no iterations, report the flagged result at once.
          state_d = ST_DONE;
          q_out_d = '1;
          r_out_d = r_dz;
          dz_d    = 1'b1;
        end else if (cnt_q == CNT_LAST) begin
          state_d = ST_DONE;
          q_out_d = q_fin;
          r_out_d = r_fin;
          dz_d    = 1'b0;
          cnt_d   = '0;
        end else begin
          acc_d = {acc_q[A_W-2:0], step_bit};
          rem_d = step_rem;
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      ST_DONE: begin
        if (i_out_ready) begin
          state_d = ST_IDLE;
          q_out_d = '0;
          r_out_d = '0;
          dz_d    = 1'b0;
        end
      end

      default: state_d = ST_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples the pre-edge values computed above.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      q_out_q <= '0;
      r_out_q <= '0;
      dz_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      q_out_q <= q_out_d;
      r_out_q <= r_out_d;
      dz_q    <= dz_d;
    end
  end

  // NOTE: the working datapath is left unreset; it is always reloaded on
  // acceptance before being read, so reset would only cost fan-out.
  always_ff @(posedge clk) begin
    acc_q <= acc_d;
    div_q <= div_d;
    rem_q <= rem_d;
`ifdef DIV_ITER_SIGNED_EN
    q_neg_q <= q_neg_d;
    r_neg_q <= r_neg_d;
`endif
  end

  assign o_out_valid = (state_q == ST_DONE);
  assign o_q         = q_out_q;
  assign o_r         = r_out_q;
  assign o_dz        = dz_q;

endmodule

// File: tb/tb_div_iter.sv
// Self-checking bench for div_iter: transaction-level reference model with a
// per-cycle compare, directed corner cases and a randomized soak.
module tb_div_iter;

  localparam int A_W = 8;
  localparam int B_W = 5;

  typedef struct packed {
    logic [A_W-1:0] q;
    logic [B_W-1:0] r;
    logic           dz;
  } res_t;

  logic           clk = 1'b0;
  logic           rst;
  logic           i_in_valid;
  logic           o_in_ready;
  logic [A_W-1:0] i_a;
  logic [B_W-1:0] i_b;
  logic           o_out_valid;
  logic           i_out_ready;
  logic [A_W-1:0] o_q;
  logic [B_W-1:0] o_r;
  logic           o_dz;

  int n_vec  = 0;
  int n_miss = 0;

  always #5 clk = ~clk;

  div_iter #(.A_W(A_W), .B_W(B_W)) dut (
    .clk         (clk),
    .rst         (rst),
    .i_in_valid  (i_in_valid),
    .o_in_ready  (o_in_ready),
    .i_a         (i_a),
    .i_b         (i_b),
    .o_out_valid (o_out_valid),
    .i_out_ready (i_out_ready),
    .o_q         (o_q),
    .o_r         (o_r),
    .o_dz        (o_dz)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Arithmetic reference: plain integer division with the divide-by-zero rule.
  function automatic res_t ref_div(input logic [A_W-1:0] a, input logic [B_W-1:0] b);
    res_t   res;
    longint sa, sb;
    if (b == '0) begin
      res.q  = '1;
      res.r  = a[B_W-1:0];
      res.dz = 1'b1;
    end else begin
`ifdef DIV_ITER_SIGNED_EN
      sa = longint'($signed(a));
      sb = longint'($signed(b));
`else
      sa = longint'(a);
      sb = longint'(b);
`endif
      res.q  = A_W'(sa / sb);
      res.r  = B_W'(sa % sb);
      res.dz = 1'b0;
    end
    return res;
  endfunction

  // Transaction-level timing: accept when idle, result A_W+1 edges later
  // (one edge for a zero divisor), held until the consumer takes it.
  bit   m_known = 1'b0;
  bit   m_idle  = 1'b1;
  bit   m_valid = 1'b0;
  int   m_wait  = 0;
  res_t m_res   = '0;

  always @(posedge clk) begin
    if (rst) begin
      m_known <= 1'b1;
      m_idle  <= 1'b1;
      m_valid <= 1'b0;
      m_wait  <= 0;
    end else if (m_idle) begin
      if (i_in_valid) begin
        m_res  <= ref_div(i_a, i_b);
        m_idle <= 1'b0;
        m_wait <= (i_b == '0) ? 1 : A_W + 1;
      end
    end else if (!m_valid) begin
      m_wait <= m_wait - 1;
      if (m_wait == 1) m_valid <= 1'b1;
    end else if (i_out_ready) begin
      m_valid <= 1'b0;
      m_idle  <= 1'b1;
    end
  end

  always @(negedge clk) begin
    if (m_known) begin
      check("in_ready",  64'(o_in_ready),  64'(m_idle));
      check("out_valid", 64'(o_out_valid), 64'(m_valid));
      check("q",  64'(o_q),  64'(m_valid ? m_res.q  : '0));
      check("r",  64'(o_r),  64'(m_valid ? m_res.r  : '0));
      check("dz", 64'(o_dz), 64'(m_valid ? m_res.dz : 1'b0));
    end
  end

  // Present one operand pair, wait for acceptance and the result, hold the
  // result for `hold` cycles while offering a stray operand, then take it.
  task automatic run_op(input logic [A_W-1:0] a, input logic [B_W-1:0] b, input int hold,
                        output int lat, output res_t got);
    int n;
    @(negedge clk);
    i_a = a; i_b = b; i_in_valid = 1'b1; i_out_ready = 1'b0;
    n = 0;
    while (!o_in_ready && n < 40) begin @(negedge clk); n++; end
    check("accept_wait", 64'(o_in_ready), 64'(1));
    @(negedge clk);
    i_in_valid = 1'b0;
    lat = 0;
    while (!o_out_valid && lat < 40) begin @(negedge clk); lat++; end
    got.q = o_q; got.r = o_r; got.dz = o_dz;
    for (int k = 0; k < hold; k++) begin
      i_in_valid = 1'b1; i_a = ~a; i_b = b + 1'b1;
      @(negedge clk);
      check("hold_in_ready", 64'(o_in_ready), 64'(0));
      check("hold_valid", 64'(o_out_valid), 64'(1));
    end
    i_in_valid = 1'b0; i_out_ready = 1'b1;
    @(negedge clk);
    i_out_ready = 1'b0;
  endtask

  initial begin
    res_t r0, got;
    int   lat, n;
    logic seen;

    rst = 1'b1; i_in_valid = 1'b0; i_out_ready = 1'b0; i_a = '0; i_b = '0;

    // Pin the model itself with hand-computed results.
    r0 = ref_div(8'h55, 5'd0);
    check("model_dz", 64'(r0), 64'({8'hFF, 5'h15, 1'b1}));
`ifdef DIV_ITER_SIGNED_EN
    r0 = ref_div(8'h9C, 5'd7);
    check("model_neg100_7", 64'(r0), 64'({8'hF2, 5'h1E, 1'b0}));
    r0 = ref_div(8'h80, 5'h1F);
    check("model_ovf", 64'(r0), 64'({8'h80, 5'h00, 1'b0}));
`else
    r0 = ref_div(8'd200, 5'd7);
    check("model_200_7", 64'(r0), 64'({8'd28, 5'd4, 1'b0}));
    r0 = ref_div(8'd255, 5'd31);
    check("model_255_31", 64'(r0), 64'({8'd8, 5'd7, 1'b0}));
`endif

    repeat (2) @(negedge clk);
    rst = 1'b0;
    check("rst_in_ready", 64'(o_in_ready), 64'(1));
    check("rst_valid", 64'(o_out_valid), 64'(0));
    check("rst_outs", 64'({o_q, o_r, o_dz}), 64'(0));

`ifdef DIV_ITER_SIGNED_EN
    run_op(8'h9C, 5'd7, 0, lat, got);
    check("neg100_7_lat", 64'(lat), 64'(9));
    check("neg100_7_res", 64'(got), 64'({8'hF2, 5'h1E, 1'b0}));
    run_op(8'h80, 5'h1F, 0, lat, got);
    check("ovf_res", 64'(got), 64'({8'h80, 5'h00, 1'b0}));
`else
    run_op(8'd200, 5'd7, 0, lat, got);
    check("200_7_lat", 64'(lat), 64'(9));
    check("200_7_res", 64'(got), 64'({8'd28, 5'd4, 1'b0}));
`endif

    run_op(8'h55, 5'd0, 0, lat, got);
    check("dz_lat", 64'(lat), 64'(1));
    check("dz_res", 64'(got), 64'({8'hFF, 5'h15, 1'b1}));

    run_op(8'd100, 5'd9, 3, lat, got);
    check("bp_lat", 64'(lat), 64'(9));
    check("bp_res", 64'(got), 64'({8'd11, 5'd1, 1'b0}));

    // Back-to-back: valid held high, consumer always ready.
    @(negedge clk);
    i_a = 8'd255; i_b = 5'd31; i_in_valid = 1'b1; i_out_ready = 1'b1;
    n = 0;
    while (!o_in_ready && n < 40) begin @(negedge clk); n++; end
    @(negedge clk);
    i_a = 8'd0; i_b = 5'd1;
    n = 0;
    while (!o_out_valid && n < 40) begin @(negedge clk); n++; end
`ifdef DIV_ITER_SIGNED_EN
    check("b2b_first", 64'({o_q, o_r}), 64'({8'd1, 5'd0}));
`else
    check("b2b_first", 64'({o_q, o_r}), 64'({8'd8, 5'd7}));
`endif
    @(negedge clk);
    n = 0;
    while (!o_out_valid && n < 40) begin @(negedge clk); n++; end
    check("b2b_second", 64'({o_q, o_r, o_dz}), 64'(0));
    check("b2b_second_valid", 64'(o_out_valid), 64'(1));
    i_in_valid = 1'b0;
    @(negedge clk);
    i_out_ready = 1'b0;

    // Reset in the middle of the iterations.
    @(negedge clk);
    i_a = 8'd250; i_b = 5'd3; i_in_valid = 1'b1; i_out_ready = 1'b1;
    n = 0;
    while (!o_in_ready && n < 40) begin @(negedge clk); n++; end
    @(negedge clk);
    i_in_valid = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("midrst_in_ready", 64'(o_in_ready), 64'(1));
    check("midrst_valid", 64'(o_out_valid), 64'(0));
    seen = 1'b0;
    repeat (20) begin
      @(negedge clk);
      if (o_out_valid) seen = 1'b1;
    end
    check("midrst_no_result", 64'(seen), 64'(0));

    // Randomized soak: every input toggles freely, including sporadic resets.
    for (int c = 0; c < 4000; c++) begin
      @(negedge clk);
      rst         = ($urandom_range(0, 399) == 0);
      i_in_valid  = ($urandom_range(0, 3) != 0);
      i_a         = A_W'($urandom);
      i_out_ready = ($urandom_range(0, 2) != 0);
      case ($urandom_range(0, 7))
        0:       i_b = '0;
        1:       i_b = '1;
        2: begin i_a = {1'b1, {(A_W-1){1'b0}}}; i_b = '1; end
        default: i_b = B_W'($urandom);
      endcase
    end
    rst = 1'b0; i_in_valid = 1'b0;
    repeat (2) @(negedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
